// File: rtl/lsu_pkg.sv
// Shared types for the LSU-to-data-memory request path: op encoding,
// in-flight tracking entries and buffered load results.
package lsu_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned ROB_TAG_WIDTH = 5;

    typedef enum logic {
        MEM_LOAD  = 1'b0,
        MEM_STORE = 1'b1
    } mem_op_t;

    typedef struct packed {
        mem_op_t                  op;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
        logic                     squashed;
    } trk_entry_t;

    typedef struct packed {
        logic [XLEN-1:0]          data;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } ld_result_t;

    typedef struct packed {
        logic                     valid;
        mem_op_t                  op;
        logic [XLEN-1:0]          addr;
        logic [XLEN-1:0]          data;
        logic [ROB_TAG_WIDTH-1:0] rob_tag;
    } issue_reg_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous clear that
// empties it in one cycle. DEPTH must be a power of two, at least 2.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/dmem_request_pipeline.sv
// Registers LSU memory requests, issues them to data memory, tracks them in
// order and returns store completions and load results (via the CDB).
module dmem_request_pipeline
    import lsu_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fire_memory_op,
    input  logic                     memory_op_type,
    input  logic [XLEN-1:0]          memory_address,
    input  logic [XLEN-1:0]          memory_data,
    input  logic [ROB_TAG_WIDTH-1:0] mem_op_rob_tag,
    input  logic                     kill_mem_req,
    input  logic                     flush,
    output logic                     mem_if_ready,
    output logic                     dmem_req_valid,
    input  logic                     dmem_req_ready,
    output logic                     dmem_req_we,
    output logic [XLEN-1:0]          dmem_req_addr,
    output logic [XLEN-1:0]          dmem_req_wdata,
    input  logic                     dmem_resp_valid,
    input  logic [XLEN-1:0]          dmem_resp_rdata,
    output logic                     load_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] load_succeeded_rob_tag,
    output logic                     store_succeeded,
    output logic [ROB_TAG_WIDTH-1:0] store_succeeded_rob_tag,
    output logic                     cdb_req,
    output logic [XLEN-1:0]          cdb_req_data,
    output logic [ROB_TAG_WIDTH-1:0] cdb_req_tag,
    input  logic                     cdb_grant
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned OCC_W = PTR_W + 1;

    issue_reg_t                 issue_q, issue_d;
    trk_entry_t                 trk_q [MAX_OUTSTANDING];
    trk_entry_t                 trk_head, trk_push;
    logic [PTR_W-1:0]           trk_wr_q, trk_rd_q;
    logic [OCC_W-1:0]           trk_cnt_q;
    logic [OCC_W-1:0]           occ_q, occ_d;
    logic                       st_succ_q;
    logic [ROB_TAG_WIDTH-1:0]   st_tag_q;

    logic                       req_hs, capture;
    logic                       resp_pop, resp_store, resp_live, resp_drop;
    logic                       res_pop, res_full, res_empty;
    logic [OCC_W-1:0]           res_count;
    ld_result_t                 res_head, res_push;

    // Issue side: occupancy bound gates the request, not the capture.
    assign dmem_req_valid = issue_q.valid & (occ_q < OCC_W'(MAX_OUTSTANDING));
    assign req_hs         = dmem_req_valid & dmem_req_ready;
    assign mem_if_ready   = ~issue_q.valid | req_hs;
    assign dmem_req_we    = (issue_q.op == MEM_STORE);
    assign dmem_req_addr  = issue_q.addr;
    assign dmem_req_wdata = issue_q.data;
    assign capture        = fire_memory_op & mem_if_ready & ~kill_mem_req
                          & ~(flush & (mem_op_t'(memory_op_type) == MEM_LOAD));

    // Flush drops a held load; a held store is committed and survives.
    always_comb begin
        issue_d = issue_q;
        if (capture) begin
            issue_d.valid   = 1'b1;
            issue_d.op      = mem_op_t'(memory_op_type);
            issue_d.addr    = memory_address;
            issue_d.data    = memory_data;
            issue_d.rob_tag = mem_op_rob_tag;
        end else if (req_hs || (flush && issue_q.op == MEM_LOAD)) begin
            issue_d = '0;
        end
    end

    // Response classification against the oldest outstanding request.
    assign trk_head   = trk_q[trk_rd_q];
    assign resp_pop   = dmem_resp_valid & (trk_cnt_q != '0);
    assign resp_store = resp_pop & (trk_head.op == MEM_STORE);
    assign resp_live  = resp_pop & (trk_head.op == MEM_LOAD) & ~trk_head.squashed & ~flush;
    assign resp_drop  = resp_pop & (trk_head.op == MEM_LOAD) & ~resp_live;

    always_comb begin
        trk_push          = '0;
        trk_push.op       = issue_q.op;
        trk_push.rob_tag  = issue_q.rob_tag;
        trk_push.squashed = flush & (issue_q.op == MEM_LOAD);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_wr_q  <= '0;
            trk_rd_q  <= '0;
            trk_cnt_q <= '0;
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            if (flush) begin
                for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                    if (trk_q[i].op == MEM_LOAD) begin
                        trk_q[i].squashed <= 1'b1;
                    end
                end
            end
            if (req_hs) begin
                trk_q[trk_wr_q] <= trk_push;
                trk_wr_q        <= trk_wr_q + PTR_W'(1);
            end
            if (resp_pop) begin
                trk_rd_q <= trk_rd_q + PTR_W'(1);
            end
            trk_cnt_q <= trk_cnt_q + OCC_W'(req_hs) - OCC_W'(resp_pop);
        end
    end

    // A live load response moves between FIFOs, so occupancy is unchanged.
    always_comb begin
        occ_d = occ_q + OCC_W'(req_hs) - OCC_W'(resp_store) - OCC_W'(resp_drop)
              - OCC_W'(res_pop);
        if (flush) begin
            occ_d = occ_d - res_count;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_q   <= '0;
            occ_q     <= '0;
            st_succ_q <= 1'b0;
            st_tag_q  <= '0;
        end else begin
            issue_q   <= issue_d;
            occ_q     <= occ_d;
            st_succ_q <= resp_store;
            st_tag_q  <= resp_store ? trk_head.rob_tag : '0;
        end
    end

    assign store_succeeded         = st_succ_q;
    assign store_succeeded_rob_tag = st_tag_q;

    always_comb begin
        res_push         = '0;
        res_push.data    = dmem_resp_rdata;
        res_push.rob_tag = trk_head.rob_tag;
    end

    sync_fifo #(
        .WIDTH ($bits(ld_result_t)),
        .DEPTH (MAX_OUTSTANDING)
    ) u_result_fifo (
        .clk         (clk),
        .rst_n       (reset),
        .clear_i     (flush),
        .push_i      (resp_live),
        .push_data_i (res_push),
        .pop_i       (res_pop),
        .head_o      (res_head),
        .count_o     (res_count),
        .full_o      (res_full),
        .empty_o     (res_empty)
    );

    assign cdb_req                = ~res_empty & ~flush;
    assign cdb_req_data           = cdb_req ? res_head.data : '0;
    assign cdb_req_tag            = cdb_req ? res_head.rob_tag : '0;
    assign res_pop                = cdb_req & cdb_grant;
    assign load_succeeded         = res_pop;
    assign load_succeeded_rob_tag = cdb_req_tag;

    a_fire_when_busy: assert property (@(posedge clk) disable iff (!reset)
        !(fire_memory_op && !mem_if_ready));
    a_resp_no_outstanding: assert property (@(posedge clk) disable iff (!reset)
        !(dmem_resp_valid && trk_cnt_q == '0));
    a_result_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(resp_live && res_full));

endmodule

// File: tb/tb_dmem_request_pipeline.sv
// Directed bench for dmem_request_pipeline: a queue-based reference model
// checked every negedge, plus hand-computed spot checks in the stimulus.
module tb_dmem_request_pipeline;

    logic        clk;
    logic        reset;
    logic        fire_memory_op;
    logic        memory_op_type;
    logic [31:0] memory_address;
    logic [31:0] memory_data;
    logic [4:0]  mem_op_rob_tag;
    logic        kill_mem_req;
    logic        flush;
    logic        mem_if_ready;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;
    logic        load_succeeded;
    logic [4:0]  load_succeeded_rob_tag;
    logic        store_succeeded;
    logic [4:0]  store_succeeded_rob_tag;
    logic        cdb_req;
    logic [31:0] cdb_req_data;
    logic [4:0]  cdb_req_tag;
    logic        cdb_grant;

    int total = 0;
    int bad   = 0;

    dmem_request_pipeline dut (
        .clk                     (clk),
        .reset                   (reset),
        .fire_memory_op          (fire_memory_op),
        .memory_op_type          (memory_op_type),
        .memory_address          (memory_address),
        .memory_data             (memory_data),
        .mem_op_rob_tag          (mem_op_rob_tag),
        .kill_mem_req            (kill_mem_req),
        .flush                   (flush),
        .mem_if_ready            (mem_if_ready),
        .dmem_req_valid          (dmem_req_valid),
        .dmem_req_ready          (dmem_req_ready),
        .dmem_req_we             (dmem_req_we),
        .dmem_req_addr           (dmem_req_addr),
        .dmem_req_wdata          (dmem_req_wdata),
        .dmem_resp_valid         (dmem_resp_valid),
        .dmem_resp_rdata         (dmem_resp_rdata),
        .load_succeeded          (load_succeeded),
        .load_succeeded_rob_tag  (load_succeeded_rob_tag),
        .store_succeeded         (store_succeeded),
        .store_succeeded_rob_tag (store_succeeded_rob_tag),
        .cdb_req                 (cdb_req),
        .cdb_req_data            (cdb_req_data),
        .cdb_req_tag             (cdb_req_tag),
        .cdb_grant               (cdb_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests and results as plain queues.
    typedef struct { bit st; bit [4:0] tag; bit sq; } oq_t;
    typedef struct { bit [31:0] d; bit [4:0] tag; } rq_t;

    oq_t outq[$];
    rq_t resq[$];
    bit        m_iv, m_ist;
    bit [31:0] m_ia, m_idt;
    bit [4:0]  m_itag;
    bit        m_st;
    bit [4:0]  m_st_tag;

    always @(negedge clk) begin : model
        bit        e_valid, e_ready, e_cdb, hs, cap;
        bit [31:0] e_cdata;
        bit [4:0]  e_ctag;
        oq_t       e, t;
        if (!reset) begin
            outq.delete(); resq.delete();
            m_iv = 0; m_ist = 0; m_ia = 0; m_idt = 0; m_itag = 0;
            m_st = 0; m_st_tag = 0;
        end
        e_valid = m_iv && ((outq.size() + resq.size()) < 4);
        e_ready = !m_iv || (e_valid && dmem_req_ready);
        e_cdb   = (resq.size() > 0) && !flush;
        e_cdata = e_cdb ? resq[0].d : 32'h0;
        e_ctag  = e_cdb ? resq[0].tag : 5'h0;
        chk("mem_if_ready", 32'(mem_if_ready), 32'(e_ready));
        chk("req_valid", 32'(dmem_req_valid), 32'(e_valid));
        chk("req_we", 32'(dmem_req_we), 32'(m_iv && m_ist));
        chk("req_addr", dmem_req_addr, m_iv ? m_ia : 32'h0);
        chk("req_wdata", dmem_req_wdata, m_iv ? m_idt : 32'h0);
        chk("cdb_req", 32'(cdb_req), 32'(e_cdb));
        chk("cdb_data", cdb_req_data, e_cdata);
        chk("cdb_tag", 32'(cdb_req_tag), 32'(e_ctag));
        chk("ld_succ", 32'(load_succeeded), 32'(e_cdb && cdb_grant));
        chk("ld_succ_tag", 32'(load_succeeded_rob_tag), 32'(e_ctag));
        chk("st_succ", 32'(store_succeeded), 32'(m_st));
        chk("st_succ_tag", 32'(store_succeeded_rob_tag), 32'(m_st_tag));
        if (reset) begin
            hs  = e_valid && dmem_req_ready;
            cap = fire_memory_op && e_ready && !kill_mem_req && !(flush && !memory_op_type);
            m_st = 0; m_st_tag = 0;
            if (e_cdb && cdb_grant) void'(resq.pop_front());
            if (dmem_resp_valid && outq.size() > 0) begin
                e = outq.pop_front();
                if (e.st) begin
                    m_st = 1; m_st_tag = e.tag;
                end else if (!e.sq && !flush) begin
                    resq.push_back('{dmem_resp_rdata, e.tag});
                end
            end
            if (flush) begin
                foreach (outq[i]) begin
                    t = outq[i];
                    if (!t.st) t.sq = 1;
                    outq[i] = t;
                end
                resq.delete();
            end
            if (hs) outq.push_back('{m_ist, m_itag, flush && !m_ist});
            if (cap) begin
                m_iv = 1; m_ist = memory_op_type; m_ia = memory_address;
                m_idt = memory_data; m_itag = mem_op_rob_tag;
            end else if (hs || (flush && m_iv && !m_ist)) begin
                m_iv = 0; m_ist = 0; m_ia = 0; m_idt = 0; m_itag = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fire_memory_op = 0; kill_mem_req = 0; flush = 0;
        dmem_resp_valid = 0; cdb_grant = 0;
    endtask

    task automatic fire_op(input bit st, input bit [31:0] a, input bit [31:0] d, input bit [4:0] t);
        fire_memory_op = 1; memory_op_type = st;
        memory_address = a; memory_data = d; mem_op_rob_tag = t;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        reset = 1; fire_memory_op = 0; memory_op_type = 0; memory_address = 0;
        memory_data = 0; mem_op_rob_tag = 0; kill_mem_req = 0; flush = 0;
        dmem_req_ready = 1; dmem_resp_valid = 0; dmem_resp_rdata = 0; cdb_grant = 0;
        #1 reset = 0;
        #1;
        chk("rst_mem_if_ready", 32'(mem_if_ready), 32'd1);
        chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        chk("rst_cdb_req", 32'(cdb_req), 32'd0);
        tick(); tick(); reset = 1;

        // Single load
        tick(); fire_op(0, 32'h100, 32'h0, 5'd3);
        tick(); #1;
        chk("ld_req_valid", 32'(dmem_req_valid), 32'd1);
        chk("ld_req_we", 32'(dmem_req_we), 32'd0);
        chk("ld_req_addr", dmem_req_addr, 32'h100);
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hDEADBEEF;
        tick(); cdb_grant = 1; #1;
        chk("ld_cdb_req", 32'(cdb_req), 32'd1);
        chk("ld_cdb_data", cdb_req_data, 32'hDEADBEEF);
        chk("ld_cdb_tag", 32'(cdb_req_tag), 32'd3);
        chk("ld_succ_pulse", 32'(load_succeeded), 32'd1);
        chk("ld_succ_tag3", 32'(load_succeeded_rob_tag), 32'd3);
        tick(); #1;
        chk("ld_cdb_drained", 32'(cdb_req), 32'd0);

        // Store with one cycle of back-pressure
        tick(); fire_op(1, 32'h200, 32'h55, 5'd5);
        tick(); dmem_req_ready = 0; #1;
        chk("st_req_valid", 32'(dmem_req_valid), 32'd1);
        chk("st_req_we", 32'(dmem_req_we), 32'd1);
        chk("st_req_wdata", dmem_req_wdata, 32'h55);
        chk("st_busy", 32'(mem_if_ready), 32'd0);
        tick(); dmem_req_ready = 1; #1;
        chk("st_wdata_held", dmem_req_wdata, 32'h55);
        tick(); dmem_resp_valid = 1;
        tick(); #1;
        chk("st_succ_pulse", 32'(store_succeeded), 32'd1);
        chk("st_succ_tag5", 32'(store_succeeded_rob_tag), 32'd5);
        chk("st_no_cdb", 32'(cdb_req), 32'd0);
        tick(); #1;
        chk("st_succ_one_cycle", 32'(store_succeeded), 32'd0);

        // Killed request leaves no state
        tick(); fire_op(0, 32'h300, 32'h0, 5'd9); kill_mem_req = 1; #1;
        chk("kill_ready", 32'(mem_if_ready), 32'd1);
        tick(); #1;
        chk("kill_no_req", 32'(dmem_req_valid), 32'd0);
        chk("kill_ready_after", 32'(mem_if_ready), 32'd1);

        // Occupancy limit: four loads outstanding, fifth waits
        for (int i = 0; i < 5; i++) begin
            tick(); fire_op(0, 32'h400 + 32'(4 * i), 32'h0, 5'(10 + i));
        end
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hA000_0000 + 32'(i);
            if (i == 0) begin
                #1;
                chk("fifth_blocked", 32'(dmem_req_valid), 32'd0);
                chk("fifth_busy", 32'(mem_if_ready), 32'd0);
            end
        end
        tick(); cdb_grant = 1; #1;
        chk("full_still_blocked", 32'(dmem_req_valid), 32'd0);
        chk("full_head_tag", 32'(cdb_req_tag), 32'd10);
        tick(); #1;
        chk("fifth_issues", 32'(dmem_req_valid), 32'd1);
        chk("fifth_addr", dmem_req_addr, 32'h410);
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hA000_0004; cdb_grant = 1;
        for (int i = 0; i < 3; i++) begin
            tick(); cdb_grant = 1;
        end
        tick(); #1;
        chk("fill_drained", 32'(cdb_req), 32'd0);

        // Flush with two loads and one store outstanding
        tick(); fire_op(0, 32'h500, 32'h0, 5'd20);
        tick(); fire_op(0, 32'h504, 32'h0, 5'd21);
        tick(); fire_op(1, 32'h508, 32'h77, 5'd22);
        tick();
        tick(); flush = 1; fire_op(0, 32'h50C, 32'h0, 5'd23); #1;
        chk("flush_ready", 32'(mem_if_ready), 32'd1);
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hBAD0; #1;
        chk("flush_drops_load_fire", 32'(dmem_req_valid), 32'd0);
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hBAD1;
        tick(); dmem_resp_valid = 1;
        tick(); #1;
        chk("flush_st_succ", 32'(store_succeeded), 32'd1);
        chk("flush_st_tag", 32'(store_succeeded_rob_tag), 32'd22);
        chk("flush_no_cdb", 32'(cdb_req), 32'd0);

        // Occupancy back at zero: a fourth outstanding load still issues
        for (int i = 0; i < 4; i++) begin
            tick(); fire_op(0, 32'h580 + 32'(4 * i), 32'h0, 5'(24 + i));
        end
        tick(); #1;
        chk("occ_zero_after_flush", 32'(dmem_req_valid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hC0 + 32'(i);
            if (i == 0) flush = 1;
        end

        // Flush coinciding with a grant
        tick(); fire_op(0, 32'h600, 32'h0, 5'd25);
        tick();
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'h600D;
        tick(); flush = 1; cdb_grant = 1; #1;
        chk("flush_masks_cdb", 32'(cdb_req), 32'd0);
        chk("flush_masks_ld_succ", 32'(load_succeeded), 32'd0);
        tick(); #1;
        chk("result_flushed", 32'(cdb_req), 32'd0);

        // Asynchronous reset with a result pending
        tick(); fire_op(0, 32'h700, 32'h0, 5'd7);
        tick();
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'h1234;
        tick(); #1;
        chk("pre_reset_cdb", 32'(cdb_req), 32'd1);
        #1 reset = 0;
        #1;
        chk("async_rst_cdb", 32'(cdb_req), 32'd0);
        chk("async_rst_data", cdb_req_data, 32'h0);
        chk("async_rst_ready", 32'(mem_if_ready), 32'd1);
        chk("async_rst_valid", 32'(dmem_req_valid), 32'd0);
        tick(); reset = 1;
        tick(); fire_op(0, 32'h704, 32'h0, 5'd8);
        tick();
        tick(); dmem_resp_valid = 1; dmem_resp_rdata = 32'hCAFE;
        tick(); cdb_grant = 1; #1;
        chk("post_rst_ld_succ", 32'(load_succeeded), 32'd1);
        chk("post_rst_tag", 32'(load_succeeded_rob_tag), 32'd8);
        chk("post_rst_data", cdb_req_data, 32'hCAFE);
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_request_pipeline.md
Name: dmem_request_pipeline

Overview:
- Sits directly downstream of the load/store unit and consumes its memory-request outputs: fire_memory_op, memory_op_type, memory_address, memory_data, kill_mem_req and the accompanying ROB tag.
- Registers each surviving request and issues it to the data memory over a valid/ready handshake.
- Tracks outstanding requests in order and produces the LSU's completion inputs: load_succeeded and store_succeeded, each with its ROB tag.
- Broadcasts load results on the CDB through a request/grant handshake.

Parameters:
XLEN, 32, data/address width
ROB_TAG_WIDTH, 5, ROB tag width
MAX_OUTSTANDING, 4, tracked requests plus buffered load results (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
fire_memory_op  in  1  LSU issues a request this cycle
memory_op_type  in  1  0=load, 1=store
memory_address  in  XLEN  request address
memory_data  in  XLEN  store data
mem_op_rob_tag  in  ROB_TAG_WIDTH  ROB tag of the fired op
kill_mem_req  in  1  same-cycle kill of the fired request
flush  in  1  squash all in-flight loads
mem_if_ready  out  1  LSU may fire this cycle
dmem_req_valid  out  1  request to memory
dmem_req_ready  in  1  memory accepts
dmem_req_we  out  1  store
dmem_req_addr  out  XLEN  address
dmem_req_wdata  out  XLEN  store data
dmem_resp_valid  in  1  in-order response, one per accepted request (loads and stores)
dmem_resp_rdata  in  XLEN  load data
load_succeeded  out  1  load result broadcast this cycle
load_succeeded_rob_tag  out  ROB_TAG_WIDTH  its tag
store_succeeded  out  1  store completed
store_succeeded_rob_tag  out  ROB_TAG_WIDTH  its tag
cdb_req  out  1  result waiting for CDB
cdb_req_data  out  XLEN  load data
cdb_req_tag  out  ROB_TAG_WIDTH  load tag
cdb_grant  in  1  CDB arbiter grant

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - issue register, tracking FIFO, result FIFO and occupancy counter;
  - all outputs go to 0, except mem_if_ready=1.
- Occupancy is the tracking FIFO count plus the result FIFO count, range 0..MAX_OUTSTANDING. Width is $clog2(MAX_OUTSTANDING)+1.
- mem_if_ready = ~issue_valid | (dmem_req_valid & dmem_req_ready). This is combinational.
- Capture:
  - On fire_memory_op & mem_if_ready & ~kill_mem_req, the issue register latches {type, addr, data, tag}.
  - A killed request leaves no state.
  - If fire_memory_op is asserted while mem_if_ready=0, the request is dropped and an assertion fires.
- dmem_req_valid = issue_valid & (occupancy < MAX_OUTSTANDING). It rises the cycle after capture at the earliest.
- Issue register contents are held stable while dmem_req_valid & ~dmem_req_ready.
- Handshake (dmem_req_valid & dmem_req_ready):
  - push {type, tag, squashed=0} to the tracking FIFO;
  - occupancy +1;
  - the issue register clears unless a new capture occurs in the same cycle.
- Response (dmem_resp_valid) pops the tracking FIFO head:
  - Store: the next cycle, store_succeeded=1 for exactly 1 cycle with the popped tag. Occupancy -1.
  - Live load: push {rdata, tag} to the result FIFO. Occupancy is unchanged.
  - Squashed load: discarded. Occupancy -1.
  - A response while the tracking FIFO is empty is a protocol error: it is ignored and an assertion fires.
- CDB:
  - cdb_req = result FIFO non-empty; cdb_req_data and cdb_req_tag show the FIFO head.
  - On cdb_req & cdb_grant: pop, occupancy -1.
  - load_succeeded = cdb_req & cdb_grant, combinational, with tag = cdb_req_tag.
- A response cannot overflow the result FIFO: the occupancy bound guarantees it.
- Flush:
  - The issue register clears if it holds a load; a store is kept, since stores are committed.
  - All tracking-FIFO load entries get squashed=1.
  - The result FIFO is emptied; occupancy is reduced by its count.
  - cdb_req and load_succeeded are forced 0 in the flush cycle.
- Simultaneous events:
  - Flush with fire: a load is not captured; a store is captured.
  - Flush with a load response: the response is treated as squashed.
  - Flush with grant: no load_succeeded.
  - Handshake and pop in the same cycle: occupancy nets correctly; the FIFO pointers wrap modulo MAX_OUTSTANDING.
- Back-to-back fires are sustained at 1/cycle while the memory is ready and occupancy allows.

Decomposition:
- lsu_pkg:
  - mem_op_t enum (MEM_LOAD=0, MEM_STORE=1);
  - trk_entry_t struct {op, rob_tag, squashed};
  - ld_result_t struct {data, rob_tag}.
- One sub-module: sync_fifo (parameterised width/depth, push/pop/count/full/empty).
  - Instantiated for the result FIFO.
  - The tracking FIFO is local, because flush must write the squashed bit across all entries.

Test Plan:
- Single load, addr 0x100, tag 3:
  - dmem_req_valid the next cycle with we=0;
  - resp rdata 0xDEADBEEF → cdb_req with data 0xDEADBEEF, tag 3;
  - grant → load_succeeded with tag 3; occupancy returns to 0.
- Store, tag 5, data 0x55 → dmem_req_we=1, wdata 0x55; resp → store_succeeded pulses 1 cycle with tag 5; cdb_req never asserted.
- Fire load with kill_mem_req=1 → no dmem_req_valid; mem_if_ready stays 1.
- Fill to MAX_OUTSTANDING=4 with loads, hold cdb_grant=0:
  - the 5th request waits in the issue register and dmem_req_valid=0;
  - the first grant frees a slot and the 5th issues the next cycle.
- Two loads outstanding plus one store, then flush before the responses:
  - the load responses are discarded and the store still yields store_succeeded;
  - occupancy returns to 0.
- Assert reset mid-operation with a result pending → all outputs 0 immediately (asynchronous), mem_if_ready=1; a later stale response is ignored.
